// File: rtl/ethpipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ethpipe_pkg                                                              |
// | Frame-word bit positions and arbiter state encoding for the eth pipe.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package ethpipe_pkg;

  localparam int FRAME_W = 18;
  localparam int SOP_BIT = 17;
  localparam int EOP_BIT = 16;

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_GNT1 = 2'b01,
    ARB_GNT2 = 2'b10
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mst_fifo_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mst_fifo_arbiter                                                         |
// | Packet-granular round-robin arbiter of two framed writers onto the       |
// | master FIFO write port. Optional counters under ARB_STATS_EN.            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module mst_fifo_arbiter
  import ethpipe_pkg::*;
`ifdef ARB_STATS_EN
#(
  parameter int STAT_W = 32
)
`endif
(
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               enable,
  input  logic [FRAME_W-1:0] src1_din,
  input  logic               src1_valid,
  output logic               src1_ready,
  input  logic [FRAME_W-1:0] src2_din,
  input  logic               src2_valid,
  output logic               src2_ready,
  output logic [FRAME_W-1:0] mst_din,
  output logic               mst_wr_en,
  input  logic               mst_full,
  output logic [1:0]         grant,
  output logic               proto_err
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]  pkt_cnt1,
  output logic [STAT_W-1:0]  pkt_cnt2,
  output logic [15:0]        drop_cnt
`endif
);

  arb_state_t         r_state;
  logic               r_last2;
  logic               r_first;
  logic               r_live;
  logic [FRAME_W-1:0] r_mst_din;
  logic               r_mst_wr_en;
  logic               r_proto_err;

  logic               w_idle;
  logic               w_rdy1;
  logic               w_rdy2;
  logic               w_acc1;
  logic               w_acc2;
  logic               w_cand1;
  logic               w_cand2;
  logic               w_pick1;
  logic               w_pick2;
  logic               w_fwd_en;
  logic [FRAME_W-1:0] w_fwd_word;
  logic               w_drop;
  logic               w_done1;
  logic               w_done2;

  // In IDLE only non-SOP words are taken (and discarded); r_live keeps ready low in reset.
  always_comb begin
    w_rdy1 = 1'b0;
    w_rdy2 = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_rdy1 = r_live & ~src1_din[SOP_BIT];
        w_rdy2 = r_live & ~src2_din[SOP_BIT];
      end
      ARB_GNT1: w_rdy1 = ~mst_full;
      ARB_GNT2: w_rdy2 = ~mst_full;
      default: ;
    endcase
  end

  assign w_idle     = (r_state == ARB_IDLE);
  assign w_acc1     = src1_valid & w_rdy1;
  assign w_acc2     = src2_valid & w_rdy2;
  assign w_cand1    = enable & src1_valid & src1_din[SOP_BIT];
  assign w_cand2    = enable & src2_valid & src2_din[SOP_BIT];
  assign w_pick1    = w_cand1 & (~w_cand2 | r_last2);
  assign w_pick2    = w_cand2 & (~w_cand1 | ~r_last2);
  assign w_fwd_en   = ((r_state == ARB_GNT1) & w_acc1) | ((r_state == ARB_GNT2) & w_acc2);
  assign w_fwd_word = (r_state == ARB_GNT2) ? src2_din : src1_din;
  assign w_drop     = w_idle & (w_acc1 | w_acc2);
  assign w_done1    = (r_state == ARB_GNT1) & w_acc1 & src1_din[EOP_BIT];
  assign w_done2    = (r_state == ARB_GNT2) & w_acc2 & src2_din[EOP_BIT];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ARB_IDLE;
      r_last2     <= 1'b1;
      r_first     <= 1'b0;
      r_live      <= 1'b0;
      r_mst_din   <= '0;
      r_mst_wr_en <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      r_mst_wr_en <= w_fwd_en;
      if (w_fwd_en) begin
        r_mst_din <= w_fwd_word;
        r_first   <= 1'b0;
      end
      if (w_drop || (w_fwd_en && w_fwd_word[SOP_BIT] && !r_first)) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        ARB_IDLE: begin
          if (w_pick1) begin
            r_state <= ARB_GNT1;
            r_first <= 1'b1;
          end else if (w_pick2) begin
            r_state <= ARB_GNT2;
            r_first <= 1'b1;
          end
        end
        ARB_GNT1: begin
          if (w_done1) begin
            r_state <= ARB_IDLE;
            r_last2 <= 1'b0;
          end
        end
        ARB_GNT2: begin
          if (w_done2) begin
            r_state <= ARB_IDLE;
            r_last2 <= 1'b1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign src1_ready = w_rdy1;
  assign src2_ready = w_rdy2;
  assign mst_din    = r_mst_din;
  assign mst_wr_en  = r_mst_wr_en;
  assign grant      = r_state;
  assign proto_err  = r_proto_err;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] r_pkt_cnt1;
  logic [STAT_W-1:0] r_pkt_cnt2;
  logic [15:0]       r_drop_cnt;
  logic [1:0]        w_drop_n;

  // Both writers can present a stray word in the same IDLE cycle.
  assign w_drop_n = {1'b0, w_idle & w_acc1} + {1'b0, w_idle & w_acc2};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pkt_cnt1 <= '0;
      r_pkt_cnt2 <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= r_drop_cnt + {14'd0, w_drop_n};
      if (w_done1) r_pkt_cnt1 <= r_pkt_cnt1 + 1'b1;
      if (w_done2) r_pkt_cnt2 <= r_pkt_cnt2 + 1'b1;
    end
  end

  assign pkt_cnt1 = r_pkt_cnt1;
  assign pkt_cnt2 = r_pkt_cnt2;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mst_fifo_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mst_fifo_arbiter                                                      |
// | Scenario tasks plus a randomized packet scoreboard for mst_fifo_arbiter. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_mst_fifo_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [17:0] src1_din = '0;
  logic        src1_valid = 1'b0;
  logic        src1_ready;
  logic [17:0] src2_din = '0;
  logic        src2_valid = 1'b0;
  logic        src2_ready;
  logic [17:0] mst_din;
  logic        mst_wr_en;
  logic        mst_full = 1'b0;
  logic [1:0]  grant;
  logic        proto_err;
`ifdef ARB_STATS_EN
  logic [31:0] pkt_cnt1;
  logic [31:0] pkt_cnt2;
  logic [15:0] drop_cnt;
`endif

  mst_fifo_arbiter u_dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .enable     (enable),
    .src1_din   (src1_din),
    .src1_valid (src1_valid),
    .src1_ready (src1_ready),
    .src2_din   (src2_din),
    .src2_valid (src2_valid),
    .src2_ready (src2_ready),
    .mst_din    (mst_din),
    .mst_wr_en  (mst_wr_en),
    .mst_full   (mst_full),
    .grant      (grant),
    .proto_err  (proto_err)
`ifdef ARB_STATS_EN
    ,
    .pkt_cnt1   (pkt_cnt1),
    .pkt_cnt2   (pkt_cnt2),
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [17:0] q1[$];
  logic [17:0] q2[$];
  bit          gap_en = 1'b0;
  bit          full_rand = 1'b0;
  int          full_from = -1;
  int          full_to = -1;
  int          wcyc[$];
  logic [17:0] wword[$];
  int          stray2 = 0;

  // One clock: drive sources at posedge+1, sample handshakes/outputs at negedge.
  task automatic cycle();
    if (q1.size() > 0 && (src1_valid || !gap_en || $urandom_range(0, 2) != 0)) begin
      src1_valid = 1'b1;
      src1_din   = q1[0];
    end else src1_valid = 1'b0;
    if (q2.size() > 0 && (src2_valid || !gap_en || $urandom_range(0, 2) != 0)) begin
      src2_valid = 1'b1;
      src2_din   = q2[0];
    end else src2_valid = 1'b0;
    mst_full = full_rand ? ($urandom_range(0, 3) == 0) : (cyc >= full_from && cyc < full_to);
    @(negedge sys_clk);
    if (mst_full && grant != 2'b00) begin
      n_cmp++;
      if ((src1_ready | src2_ready) !== 1'b0) begin
        n_fail++;
        $display("FAIL full_ready cyc=%0d: ready1=%b ready2=%b expected 0", cyc, src1_ready, src2_ready);
      end
    end
    if (src1_valid && src1_ready) void'(q1.pop_front());
    if (src2_valid && src2_ready) begin
      if (!src2_din[17]) stray2++;
      void'(q2.pop_front());
    end
    if (mst_wr_en === 1'b1) begin
      wcyc.push_back(cyc);
      wword.push_back(mst_din);
    end
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_log();
    wcyc.delete();
    wword.delete();
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    q1.delete();
    q2.delete();
    src1_valid = 1'b0;
    src2_valid = 1'b0;
    enable = 1'b1;
    mst_full = 1'b0;
    full_from = -1;
    full_to = -1;
    gap_en = 1'b0;
    full_rand = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  // Compare the write log against an expected word list and (optionally) cycles.
  task automatic check_log(input string nm, input logic [17:0] ew[$], input int ec[$]);
    n_cmp++;
    if (wword.size() != ew.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d writes expected %0d", nm, wword.size(), ew.size());
    end
    for (int i = 0; i < ew.size() && i < wword.size(); i++) begin
      n_cmp++;
      if (wword[i] !== ew[i]) begin
        n_fail++;
        $display("FAIL %s_word[%0d]: got %h expected %h", nm, i, wword[i], ew[i]);
      end
      if (i < ec.size()) begin
        n_cmp++;
        if (wcyc[i] != ec[i]) begin
          n_fail++;
          $display("FAIL %s_cycle[%0d]: got %0d expected %0d", nm, i, wcyc[i], ec[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    src1_valid = 1'b1;
    src1_din = 18'h00001;
    src2_valid = 1'b1;
    src2_din = 18'h20002;
    repeat (2) @(posedge sys_clk);
    #1;
    n_cmp++;
    if ({src1_ready, src2_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 00", {src1_ready, src2_ready});
    end
    apply_reset();
    n_cmp++;
    if (mst_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", mst_wr_en); end
    n_cmp++;
    if (mst_din !== 18'h0) begin n_fail++; $display("FAIL reset_din: got %h expected 0", mst_din); end
    n_cmp++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", grant); end
    n_cmp++;
    if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
`ifdef ARB_STATS_EN
    n_cmp++;
    if (pkt_cnt1 !== 0 || pkt_cnt2 !== 0 || drop_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", pkt_cnt1, pkt_cnt2, drop_cnt);
    end
`endif
  endtask

  task automatic test_single();
    logic [17:0] ew[$];
    int ec[$];
    int c0;
    run(2);
    clear_log();
    c0 = cyc;
    ew = '{18'h290ff, 18'h01234, 18'h15678};
    ec = '{c0 + 2, c0 + 3, c0 + 4};
    foreach (ew[i]) q1.push_back(ew[i]);
    run(8);
    check_log("single", ew, ec);
`ifdef ARB_STATS_EN
    n_cmp++;
    if (pkt_cnt1 !== 32'd1) begin n_fail++; $display("FAIL single_pkt_cnt1: got %0d expected 1", pkt_cnt1); end
`endif
  endtask

  task automatic test_round_robin();
    logic [17:0] ew[$];
    int ec[$];
    int c0;
    apply_reset();
    run(2);
    clear_log();
    c0 = cyc;
    q1 = '{18'h21111, 18'h12222};
    q2 = '{18'h23333, 18'h04444, 18'h15555};
    // Channel 1 wins (last grant resets to 2); channel 2 follows after one idle cycle.
    ew = '{18'h21111, 18'h12222, 18'h23333, 18'h04444, 18'h15555};
    ec = '{c0 + 2, c0 + 3, c0 + 5, c0 + 6, c0 + 7};
    run(12);
    check_log("rr_pair1", ew, ec);
    clear_log();
    c0 = cyc;
    q1 = '{18'h3aaaa};
    q2 = '{18'h2bbbb, 18'h1cccc};
    ew = '{18'h3aaaa, 18'h2bbbb, 18'h1cccc};
    ec = '{c0 + 2, c0 + 4, c0 + 5};
    run(10);
    check_log("rr_pair2", ew, ec);
  endtask

  task automatic test_full_stall();
    logic [17:0] ew[$];
    int ec[$];
    int c0;
    int c;
    clear_log();
    c0 = cyc;
    ew = '{18'h20100, 18'h00101, 18'h00102, 18'h00103, 18'h00104, 18'h00105, 18'h00106, 18'h10107};
    foreach (ew[i]) q1.push_back(ew[i]);
    full_from = c0 + 3;
    full_to   = c0 + 8;
    c = c0 + 1;
    while (ec.size() < ew.size()) begin
      if (!(c >= full_from && c < full_to)) ec.push_back(c + 1);
      c++;
    end
    run(20);
    full_from = -1;
    full_to = -1;
    check_log("full_stall", ew, ec);
  endtask

  task automatic test_stray();
    logic [17:0] ew[$];
    int ec[$];
    apply_reset();
    run(2);
    clear_log();
    stray2 = 0;
    q2.push_back(18'h0abcd);
    run(1);
    n_cmp++;
    if (stray2 != 1) begin n_fail++; $display("FAIL stray_ready: got %0d accepts expected 1", stray2); end
    run(4);
    check_log("stray_nowrite", ew, ec);
    n_cmp++;
    if (proto_err !== 1'b1) begin n_fail++; $display("FAIL stray_proto_err: got %b expected 1", proto_err); end
    n_cmp++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL stray_grant: got %b expected 00", grant); end
`ifdef ARB_STATS_EN
    n_cmp++;
    if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL stray_drop_cnt: got %0d expected 1", drop_cnt); end
`endif
  endtask

  task automatic test_enable();
    logic [17:0] ew[$];
    int ec[$];
    clear_log();
    ew = '{18'h20201, 18'h00202, 18'h00203, 18'h10204};
    foreach (ew[i]) q1.push_back(ew[i]);
    run(2);
    enable = 1'b0;
    q2 = '{18'h20301, 18'h10302};
    run(10);
    check_log("enable_off", ew, ec);
    n_cmp++;
    if (grant !== 2'b00 || q2.size() != 2) begin
      n_fail++;
      $display("FAIL enable_hold: grant=%b pending=%0d expected 00 and 2", grant, q2.size());
    end
    enable = 1'b1;
    clear_log();
    ew = '{18'h20301, 18'h10302};
    run(6);
    check_log("enable_on", ew, ec);
  endtask

  task automatic test_reset_mid();
    logic [17:0] ew[$];
    int ec[$];
    int c0;
    q1 = '{18'h20401, 18'h00402, 18'h00403, 18'h00404, 18'h10405};
    run(3);
    #2;
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mst_wr_en, mst_din, grant, src1_ready, src2_ready, proto_err} !== 24'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: wr_en=%b din=%h grant=%b rdy=%b%b perr=%b expected all 0",
               mst_wr_en, mst_din, grant, src1_ready, src2_ready, proto_err);
    end
    q1.delete();
    src1_valid = 1'b0;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    run(1);
    clear_log();
    c0 = cyc;
    ew = '{18'h20501, 18'h10502};
    ec = '{c0 + 2, c0 + 3};
    foreach (ew[i]) q1.push_back(ew[i]);
    run(6);
    check_log("after_reset", ew, ec);
  endtask

  task automatic test_random();
    logic [17:0] e1[$];
    logic [17:0] e2[$];
    logic [17:0] w;
    int owner;
    int ch;
    int budget;
    int npkt;
    int len;
    apply_reset();
    run(1);
    clear_log();
    npkt = 15;
    for (int c = 1; c <= 2; c++) begin
      for (int p = 0; p < npkt; p++) begin
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) begin
          w = {(i == 0), (i == len - 1), (c == 2), 15'($urandom)};
          if (c == 1) begin q1.push_back(w); e1.push_back(w); end
          else begin q2.push_back(w); e2.push_back(w); end
        end
      end
    end
    gap_en = 1'b1;
    full_rand = 1'b1;
    budget = 3000;
    while ((q1.size() > 0 || q2.size() > 0) && budget > 0) begin
      cycle();
      budget--;
    end
    gap_en = 1'b0;
    full_rand = 1'b0;
    run(4);
    n_cmp++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL random_timeout: pending %0d/%0d words expected 0/0", q1.size(), q2.size());
    end
    // Packets never interleave and each channel's words arrive once, in order.
    owner = 0;
    foreach (wword[i]) begin
      w = wword[i];
      ch = w[15] ? 2 : 1;
      n_cmp++;
      if (owner != 0 && ch != owner) begin
        n_fail++;
        $display("FAIL random_interleave[%0d]: got channel %0d expected %0d", i, ch, owner);
      end
      n_cmp++;
      if (ch == 1 && (e1.size() == 0 || e1[0] !== w)) begin
        n_fail++;
        $display("FAIL random_ch1_word[%0d]: got %h expected %h", i, w, (e1.size() > 0) ? e1[0] : 18'h0);
      end else if (ch == 2 && (e2.size() == 0 || e2[0] !== w)) begin
        n_fail++;
        $display("FAIL random_ch2_word[%0d]: got %h expected %h", i, w, (e2.size() > 0) ? e2[0] : 18'h0);
      end
      if (ch == 1 && e1.size() > 0) void'(e1.pop_front());
      if (ch == 2 && e2.size() > 0) void'(e2.pop_front());
      owner = w[16] ? 0 : ch;
    end
    n_cmp++;
    if (e1.size() != 0 || e2.size() != 0) begin
      n_fail++;
      $display("FAIL random_missing: got %0d/%0d undelivered expected 0/0", e1.size(), e2.size());
    end
    n_cmp++;
    if (proto_err !== 1'b0) begin n_fail++; $display("FAIL random_proto_err: got %b expected 0", proto_err); end
`ifdef ARB_STATS_EN
    n_cmp++;
    if (pkt_cnt1 !== npkt || pkt_cnt2 !== npkt) begin
      n_fail++;
      $display("FAIL random_pkt_cnt: got %0d/%0d expected %0d/%0d", pkt_cnt1, pkt_cnt2, npkt, npkt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_stray();
    test_enable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mst_fifo_arbiter.md
# mst_fifo_arbiter

Packet-granular two-way round-robin arbiter sharing the single master FIFO write port between the phy1 and phy2 receive packet writers. Each writer emits 18-bit framed words (bit 17 = start of packet, bit 16 = end of packet, bits 15:0 = payload). The arbiter grants one writer at a time, never interleaves packets, and forwards words to the master FIFO through a registered stage.

## Interface
- Parameters:
- STAT_W, 32: width of the per-channel packet counters (ARB_STATS_EN only)
- Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  new grants allowed when high (tied to dma_status[0])
- src1_din  in  18  channel 1 framed word
- src1_valid  in  1  channel 1 word present
- src1_ready  out  1  channel 1 word accepted this cycle when valid&ready
- src2_din  in  18  channel 2 framed word
- src2_valid  in  1  channel 2 word present
- src2_ready  out  1  channel 2 word accepted
- mst_din  out  18  word to master FIFO (registered)
- mst_wr_en  out  1  master FIFO write strobe (registered)
- mst_full  in  1  master FIFO almost-full; asserted with at least 2 free entries remaining
- grant  out  2  one-hot current owner, 00 when idle
- proto_err  out  1  sticky framing error flag
- pkt_cnt1, pkt_cnt2  out  STAT_W  packets forwarded per channel (ARB_STATS_EN only)
- drop_cnt  out  16  stray words discarded (ARB_STATS_EN only)

## Operation
- States: IDLE, GNT1, GNT2. Reset state IDLE; last_grant register resets to channel 2, so channel 1 wins the first tie.
- IDLE, enable=1: a candidate is a channel with valid=1 and din[17]=1.
  - Only one candidate: grant it.
  - Both: grant the channel not equal to last_grant.
  - None: stay in IDLE.
- IDLE, enable=0: no grant.
- IDLE, valid=1 with din[17]=0 on any channel: the word is stray. Assert ready for that channel, discard the word, increment drop_cnt, set proto_err. This applies regardless of enable.
- GNTn: srcn_ready = ~mst_full. The other channel's ready = 0.
- Each accepted word is copied unchanged to mst_din, with mst_wr_en=1 on the next cycle.
- Accepted word with bit 16 set: set last_grant=n, increment pkt_cntn, return to IDLE.
- A single-word packet (bits 17 and 16 both set) is legal. It completes in one accepted cycle.
- Accepted word with bit 17 set while in GNTn (not the first word): forward it, set proto_err, keep the grant.
- enable falling mid-packet: the current packet runs to its EOP. No new grant after that.
- Valid dropping mid-packet: hold the grant indefinitely. There is no timeout.
- mst_wr_en=0 in every cycle without an accepted word. mst_din holds its last value.
- Counters wrap modulo 2^width. proto_err clears only on reset.

## Timing
- Reset values: mst_din=0, mst_wr_en=0, grant=00, proto_err=0, all counters 0. src*_ready=0 during reset.
- ready is combinational from the state register and mst_full. There is no path from valid to ready.
- Arbitration:
  - Cycle t: SOP valid in IDLE.
  - Cycle t+1: grant set and ready may assert.
  - First word lands on mst_din/mst_wr_en at t+2.
- Throughput: one word per cycle within a packet. Exactly one IDLE bubble between consecutive packets.
- Write-to-output latency: 1 cycle.
- The registered output stage means one write can land after mst_full rises. This is covered by the required 2-entry almost-full margin.
- Asynchronous reset mid-packet: the packet is truncated, state returns to IDLE, and the writer restarts at its next SOP.

## Configuration
- ARB_STATS_EN defined: pkt_cnt1, pkt_cnt2 and drop_cnt ports and counters exist.
- Not defined: those ports and registers are omitted. proto_err and all arbitration behaviour are unchanged.

## Structure
- Shared package (ethpipe_pkg) holds:
  - frame bit indices SOP_BIT=17, EOP_BIT=16
  - state encoding constants ARB_IDLE, ARB_GNT1, ARB_GNT2
- No sub-module needed. The counters are inline, wrapped by the ARB_STATS_EN guard.

## Test plan
- Channel 1 alone sends a 3-word packet 0x290ff, 0x01234, 0x15678 → mst_wr_en pulses 3 cycles with identical words, first word 2 cycles after SOP valid, pkt_cnt1=1.
- Both channels present SOP on the same cycle after reset → channel 1 is served fully, then channel 2 after one bubble; a second simultaneous pair → order is 1, then 2 again.
- mst_full asserted for 5 cycles mid-packet → ready=0 and no writes for those cycles; resumes with no word lost or duplicated.
- Stray word 0x0abcd (no SOP) on channel 2 in IDLE → ready pulses, no mst write, drop_cnt=1, proto_err=1.
- enable deasserted during a channel 1 packet → packet completes through EOP; a pending channel 2 SOP is not granted until enable=1.
- sys_rst_n asserted mid-packet → all outputs return to reset values immediately; the next SOP is arbitrated normally.
